// File: rtl/alsu_chk_pkg.sv
// Shared types and widths for the ALSU result checker.
//   chk_state_e : checker FSM states
//   OUT_W       : width of the ALSU result bus
//   LEDS_W      : width of the ALSU leds bus
package alsu_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  localparam int OUT_W  = 6;
  localparam int LEDS_W = 16;

endpackage

// File: rtl/alsu_valid_delay.sv
// Fixed-latency valid pipeline: vld is launch delayed by exactly LATENCY
// clock cycles.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low clear of the whole line
//   launch : stimulus launched this cycle
//   vld    : launch from LATENCY cycles ago
module alsu_valid_delay #(
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic launch,
  output logic vld
);

  logic [LATENCY-1:0] sr_q;
  logic [LATENCY-1:0] sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = launch;
    for (int i = 1; i < LATENCY; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign vld = sr_q[LATENCY-1];

endmodule

// File: rtl/alsu_result_checker.sv
// Receive-side checker for the ALSU DUT / golden-model pair. Each launched
// stimulus is compared LATENCY cycles later; compares and mismatches are
// counted (saturating) and the first mismatch is captured.
// Ports:
//   clk, reset              : clock; asynchronous active-low reset
//   start, stop, sample_en  : arm checker / end stimulus / stimulus applied
//   out, out_golden_model   : DUT and golden results
//   leds, leds_golden_model : DUT and golden leds
//   busy, done, pass        : RUN|DRAIN, DONE, DONE with no mismatches
//   mismatch, err_sticky    : per-fail pulse, first-fail flag
//   chk_cnt, err_cnt        : compare and mismatch counters
//   first_idx, first_out_*  : capture of the first failing compare
module alsu_result_checker
  import alsu_chk_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int CNT_W      = 16,
  parameter bit CHECK_LEDS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              sample_en,
  input  logic [OUT_W-1:0]  out,
  input  logic [OUT_W-1:0]  out_golden_model,
  input  logic [LEDS_W-1:0] leds,
  input  logic [LEDS_W-1:0] leds_golden_model,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              mismatch,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  chk_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_idx,
  output logic [OUT_W-1:0]  first_out_dut,
  output logic [OUT_W-1:0]  first_out_gold
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_e       state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] chk_q, chk_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;
  logic [OUT_W-1:0] fdut_q, fdut_d;
  logic [OUT_W-1:0] fgold_q, fgold_d;
  logic             sticky_q, sticky_d;
  logic             mism_q, mism_d;

  logic launch;
  logic vld;
  logic cmp;
  logic fail;
  logic clear;

  // The cycle carrying stop marks the end of stimulus, so it launches
  // nothing; only launches from earlier RUN cycles are drained.
  assign launch = sample_en && (state_q == RUN) && !stop;

  alsu_valid_delay #(
    .LATENCY (LATENCY)
  ) u_vdly (
    .clk    (clk),
    .rst_n  (reset),
    .launch (launch),
    .vld    (vld)
  );

  assign cmp = vld && ((state_q == RUN) || (state_q == DRAIN));

  // Case-inequality so that X/Z on any compared bit is reported as a fail.
  assign fail = (out !== out_golden_model) ||
                (CHECK_LEDS && (leds !== leds_golden_model));

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    clear   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = DRAIN;
          drain_d = 4'(LATENCY);
        end
      end
      DRAIN: begin
        drain_d = drain_q - 4'd1;
        if (drain_q == 4'd1) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    chk_d    = chk_q;
    err_d    = err_q;
    fidx_d   = fidx_q;
    fdut_d   = fdut_q;
    fgold_d  = fgold_q;
    sticky_d = sticky_q;
    mism_d   = 1'b0;
    if (clear) begin
      chk_d    = '0;
      err_d    = '0;
      fidx_d   = '0;
      fdut_d   = '0;
      fgold_d  = '0;
      sticky_d = 1'b0;
    end else if (cmp) begin
      if (chk_q != CNT_MAX) chk_d = chk_q + 1'b1;
      if (fail) begin
        if (err_q != CNT_MAX) err_d = err_q + 1'b1;
        mism_d   = 1'b1;
        sticky_d = 1'b1;
        if (!sticky_q) begin
          fidx_d  = chk_q;
          fdut_d  = out;
          fgold_d = out_golden_model;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      drain_q  <= '0;
      chk_q    <= '0;
      err_q    <= '0;
      fidx_q   <= '0;
      fdut_q   <= '0;
      fgold_q  <= '0;
      sticky_q <= 1'b0;
      mism_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      chk_q    <= chk_d;
      err_q    <= err_d;
      fidx_q   <= fidx_d;
      fdut_q   <= fdut_d;
      fgold_q  <= fgold_d;
      sticky_q <= sticky_d;
      mism_q   <= mism_d;
    end
  end

  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign pass           = done && (err_q == '0);
  assign mismatch       = mism_q;
  assign err_sticky     = sticky_q;
  assign chk_cnt        = chk_q;
  assign err_cnt        = err_q;
  assign first_idx      = fidx_q;
  assign first_out_dut  = fdut_q;
  assign first_out_gold = fgold_q;

endmodule

// File: tb/tb_alsu_result_checker.sv
// Bench for alsu_result_checker: three instances share one stimulus stream
// (default, CHECK_LEDS=0, CNT_W=4). Table-driven scenarios plus hand-written
// sequences for stop/launch overlap, mid-run reset and restart from DONE.
module tb_alsu_result_checker;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        sample_en = 1'b0;
  logic [5:0]  out_v = '0;
  logic [5:0]  gold_v = '0;
  logic [15:0] leds_v = '0;
  logic [15:0] lgold_v = '0;

  logic        a_busy, a_done, a_pass, a_mismatch, a_sticky;
  logic [15:0] a_chk, a_err, a_fidx;
  logic [5:0]  a_fdut, a_fgold;
  logic        b_busy, b_done, b_pass, b_mismatch, b_sticky;
  logic [15:0] b_chk, b_err, b_fidx;
  logic [5:0]  b_fdut, b_fgold;
  logic        c_busy, c_done, c_pass, c_mismatch, c_sticky;
  logic [3:0]  c_chk, c_err, c_fidx;
  logic [5:0]  c_fdut, c_fgold;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alsu_result_checker #(.LATENCY(LAT), .CNT_W(16), .CHECK_LEDS(1'b1)) u_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .sample_en(sample_en),
    .out(out_v), .out_golden_model(gold_v), .leds(leds_v), .leds_golden_model(lgold_v),
    .busy(a_busy), .done(a_done), .pass(a_pass), .mismatch(a_mismatch),
    .err_sticky(a_sticky), .chk_cnt(a_chk), .err_cnt(a_err), .first_idx(a_fidx),
    .first_out_dut(a_fdut), .first_out_gold(a_fgold));

  alsu_result_checker #(.LATENCY(LAT), .CNT_W(16), .CHECK_LEDS(1'b0)) u_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .sample_en(sample_en),
    .out(out_v), .out_golden_model(gold_v), .leds(leds_v), .leds_golden_model(lgold_v),
    .busy(b_busy), .done(b_done), .pass(b_pass), .mismatch(b_mismatch),
    .err_sticky(b_sticky), .chk_cnt(b_chk), .err_cnt(b_err), .first_idx(b_fidx),
    .first_out_dut(b_fdut), .first_out_gold(b_fgold));

  alsu_result_checker #(.LATENCY(LAT), .CNT_W(4), .CHECK_LEDS(1'b1)) u_c (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .sample_en(sample_en),
    .out(out_v), .out_golden_model(gold_v), .leds(leds_v), .leds_golden_model(lgold_v),
    .busy(c_busy), .done(c_done), .pass(c_pass), .mismatch(c_mismatch),
    .err_sticky(c_sticky), .chk_cnt(c_chk), .err_cnt(c_err), .first_idx(c_fidx),
    .first_out_dut(c_fdut), .first_out_gold(c_fgold));

  typedef struct {
    int n;       // launches
    int mode;    // 0 clean, 1 single out fail at idx 6, 2 leds differ, 3 all out fail
    int a_chk;
    int a_err;
    int a_first;
    int a_fdut;
    int a_fgold;
    int a_pass;
    int b_err;
    int c_chk;
    int c_err;
  } scn_t;

  scn_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Values presented on the compare cycle of launch j; outside 0..n-1 the
  // buses are equal so stray compares would not look like failures.
  task automatic set_vec(input int mode, input int j, input int n);
    out_v = '0; gold_v = '0; leds_v = 16'hA5A5; lgold_v = 16'hA5A5;
    if (j >= 0 && j < n) begin
      out_v  = 6'(j);
      gold_v = 6'(j);
      case (mode)
        1: if (j == 6) begin out_v = 6'h15; gold_v = 6'h14; end
        2: begin leds_v = 16'hFFFF; lgold_v = 16'h0000; end
        3: gold_v = 6'(j) ^ 6'h3F;
        default: ;
      endcase
    end
  endtask

  // start pulse, n back-to-back launches, stop on cycle stop_k, run until
  // all in-flight compares have had time to land. Returns mismatch pulses.
  task automatic run_seq(input int mode, input int n, input int stop_k, output int pulses);
    pulses = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= stop_k + LAT + 1; k++) begin
      sample_en = (k < n);
      stop      = (k == stop_k);
      set_vec(mode, k - LAT, n);
      @(negedge clk);
      pulses += int'(a_mismatch);
    end
    sample_en = 1'b0;
    stop      = 1'b0;
    set_vec(0, -1, 0);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 20 && !a_done; i++) @(negedge clk);
    check({name, "_done"}, 32'(a_done), 32'd1);
  endtask

  initial begin
    int pulses;
    tbl[0] = '{20, 0, 20, 0,  0, 0,     0,     1, 0,  15, 0};
    tbl[1] = '{10, 1, 10, 1,  6, 'h15,  'h14,  0, 1,  10, 1};
    tbl[2] = '{5,  2, 5,  5,  0, 0,     0,     0, 0,  5,  5};
    tbl[3] = '{20, 3, 20, 20, 0, 0,     'h3F,  0, 20, 15, 15};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_done", 32'(a_done), 0);
    check("rst_pass", 32'(a_pass), 0);
    check("rst_chk", 32'(a_chk), 0);
    check("rst_err", 32'(a_err), 0);
    reset = 1'b1;
    @(negedge clk);

    // stop/start in IDLE with stop only: ignored
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    check("idle_stop_busy", 32'(a_busy), 0);

    for (int s = 0; s < 4; s++) begin
      string p;
      p = $sformatf("scn%0d", s);
      run_seq(tbl[s].mode, tbl[s].n, tbl[s].n, pulses);
      wait_done(p);
      check({p, "_chk"}, 32'(a_chk), 32'(tbl[s].a_chk));
      check({p, "_err"}, 32'(a_err), 32'(tbl[s].a_err));
      check({p, "_pulses"}, 32'(pulses), 32'(tbl[s].a_err));
      check({p, "_sticky"}, 32'(a_sticky), 32'(tbl[s].a_err != 0));
      check({p, "_fidx"}, 32'(a_fidx), 32'(tbl[s].a_first));
      check({p, "_fdut"}, 32'(a_fdut), 32'(tbl[s].a_fdut));
      check({p, "_fgold"}, 32'(a_fgold), 32'(tbl[s].a_fgold));
      check({p, "_pass"}, 32'(a_pass), 32'(tbl[s].a_pass));
      check({p, "_noled_err"}, 32'(b_err), 32'(tbl[s].b_err));
      check({p, "_noled_pass"}, 32'(b_pass), 32'(tbl[s].b_err == 0));
      check({p, "_c4_chk"}, 32'(c_chk), 32'(tbl[s].c_chk));
      check({p, "_c4_err"}, 32'(c_err), 32'(tbl[s].c_err));
      check({p, "_c4_pass"}, 32'(c_pass), 32'(tbl[s].c_err == 0));
    end

    // Restart from DONE after saturation: full clear
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("restart_c4_chk", 32'(c_chk), 0);
    check("restart_c4_err", 32'(c_err), 0);
    check("restart_c4_sticky", 32'(c_sticky), 0);
    check("restart_a_fgold", 32'(a_fgold), 0);
    check("restart_busy", 32'(a_busy), 1);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    wait_done("restart");
    check("restart_chk_after", 32'(a_chk), 0);

    // stop on the same cycle as the last sample_en: that launch is dropped
    run_seq(0, 3, 2, pulses);
    wait_done("stop_same");
    check("stop_same_chk", 32'(a_chk), 2);
    // stop one cycle after the last launch: it lands during DRAIN
    run_seq(0, 3, 3, pulses);
    wait_done("stop_after");
    check("stop_after_chk", 32'(a_chk), 3);

    // Mid-run reset with launches in flight
    start = 1'b1; @(negedge clk); start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sample_en = 1'b1;
      set_vec(3, k - LAT, 100);
      @(negedge clk);
    end
    check("pre_rst_err", 32'(a_err), 4);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", 32'(a_busy), 0);
    check("midrst_chk", 32'(a_chk), 0);
    check("midrst_err", 32'(a_err), 0);
    check("midrst_sticky", 32'(a_sticky), 0);
    check("midrst_fdut_fgold", 32'({a_fdut, a_fgold}), 0);
    check("midrst_mismatch", 32'(a_mismatch), 0);
    sample_en = 1'b0;
    set_vec(0, -1, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("postrst_chk", 32'(a_chk), 0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("restart_chk_zero", 32'(a_chk), 0);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    wait_done("postrst_empty");
    run_seq(0, 3, 3, pulses);
    wait_done("postrst");
    check("postrst_run_chk", 32'(a_chk), 3);
    check("postrst_run_pass", 32'(a_pass), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
